// File: rtl/heap_shift_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : heap_shift_sequencer                                           |
// | Brief   : Sequences array insert (shiftUp) and remove (shiftDown) over a |
// |           single-port heap RAM, one element per two cycles. Owns the     |
// |           per-array size table.                                          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module heap_shift_sequencer #(
  parameter  int MemoryElementWidth = 12,
  parameter  int NArea              = 4,
  parameter  int NArrays            = 2,
  localparam int MEW                = MemoryElementWidth,
  localparam int AW                 = $clog2(NArea * NArrays)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cmdValid,
  output logic           cmdReady,
  input  logic           cmdOp,
  input  logic [MEW-1:0] cmdArray,
  input  logic [MEW-1:0] cmdIndex,
  input  logic [MEW-1:0] cmdValue,
  input  logic           sizeWe,
  input  logic [MEW-1:0] sizeArray,
  input  logic [MEW-1:0] sizeValue,
  output logic           respValid,
  input  logic           respReady,
  output logic           respError,
  output logic [MEW-1:0] respValue,
  output logic [MEW-1:0] respSize,
  output logic [AW-1:0]  memAddr,
  output logic           memWe,
  output logic [MEW-1:0] memWData,
  input  logic [MEW-1:0] memRData
);

  localparam int             SW        = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [MEW-1:0] C_NAREA   = MEW'(NArea);
  localparam logic [MEW-1:0] C_NARRAYS = MEW'(NArrays);
  localparam logic [MEW-1:0] C_ONE     = MEW'(1);
  localparam logic [AW-1:0]  C_AONE    = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WRITE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_INSERT  = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t         state_q;
  logic           op_q;
  logic [MEW-1:0] arr_q;
  logic [AW-1:0]  base_q;
  logic [MEW-1:0] idx_q;
  logic [MEW-1:0] val_q;
  logic [MEW-1:0] i_q;
  logic [MEW-1:0] s_q;
  logic [MEW-1:0] size_q [NArrays];
  logic           cmdReady_q;
  logic           respValid_q;
  logic           respError_q;
  logic [MEW-1:0] respValue_q;
  logic [MEW-1:0] respSize_q;

  logic           size_ok_d;
  logic [MEW-1:0] size_clamped_d;
  logic           accept_d;
  logic           arr_ok_d;
  logic [MEW-1:0] s_d;
  logic           err_d;
  logic [AW-1:0]  base_d;
  logic [MEW-1:0] up_size_d;

  assign cmdReady  = cmdReady_q;
  assign respValid = respValid_q;
  assign respError = respError_q;
  assign respValue = respValue_q;
  assign respSize  = respSize_q;

  // Command decode: effective size (a same-cycle resize lands first), error check, area base.
  always_comb begin
    size_ok_d      = sizeWe && (sizeArray < C_NARRAYS) &&
                     !((state_q != S_IDLE) && (sizeArray == arr_q));
    size_clamped_d = (sizeValue > C_NAREA) ? C_NAREA : sizeValue;
    accept_d       = cmdValid && cmdReady_q;
    arr_ok_d       = cmdArray < C_NARRAYS;
    s_d            = '0;
    if (arr_ok_d) begin
      if (size_ok_d && (sizeArray == cmdArray)) s_d = size_clamped_d;
      else                                      s_d = size_q[cmdArray[SW-1:0]];
    end
    err_d = !arr_ok_d ||
            (!cmdOp && ((cmdIndex > s_d) || (cmdIndex >= C_NAREA))) ||
            ( cmdOp && (cmdIndex >= s_d));
    base_d    = AW'(C_NAREA * cmdArray);
    up_size_d = (s_q >= C_NAREA) ? C_NAREA : (s_q + C_ONE);
  end

  // Heap bus: addresses and write strobes derived from the current move position.
  always_comb begin
    memAddr  = '0;
    memWe    = 1'b0;
    memWData = '0;
    case (state_q)
      S_READ: begin
        memAddr = base_q + AW'(i_q);
      end
      S_WRITE: begin
        memWData = memRData;
        if (!op_q) begin
          memAddr = base_q + AW'(i_q) + C_AONE;
          // The element shifted past the end of a full area is discarded.
          memWe   = (i_q + C_ONE) < C_NAREA;
        end else begin
          memAddr = base_q + AW'(i_q) - C_AONE;
          memWe   = 1'b1;
        end
      end
      S_INSERT: begin
        memAddr  = base_q + AW'(idx_q);
        memWData = val_q;
        memWe    = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer FSM, size table and registered response/handshake outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      arr_q       <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      val_q       <= '0;
      i_q         <= '0;
      s_q         <= '0;
      cmdReady_q  <= 1'b0;
      respValid_q <= 1'b0;
      respError_q <= 1'b0;
      respValue_q <= '0;
      respSize_q  <= '0;
      for (int a = 0; a < NArrays; a++) size_q[a] <= '0;
    end else begin
      if (size_ok_d) size_q[sizeArray[SW-1:0]] <= size_clamped_d;

      case (state_q)
        S_IDLE: begin
          cmdReady_q <= 1'b1;
          if (accept_d) begin
            cmdReady_q  <= 1'b0;
            op_q        <= cmdOp;
            arr_q       <= cmdArray;
            idx_q       <= cmdIndex;
            val_q       <= cmdValue;
            base_q      <= base_d;
            s_q         <= s_d;
            respValue_q <= '0;
            if (err_d) begin
              respValid_q <= 1'b1;
              respError_q <= 1'b1;
              respSize_q  <= s_d;
              state_q     <= S_RESP;
            end else if (!cmdOp) begin
              // Shift from the top element down to the insertion point.
              if (cmdIndex == s_d) begin
                state_q <= S_INSERT;
              end else begin
                i_q     <= s_d - C_ONE;
                state_q <= S_READ;
              end
            end else begin
              // First read fetches the element being removed.
              i_q     <= cmdIndex;
              state_q <= S_READ;
            end
          end
        end

        S_READ: begin
          state_q <= (op_q && (i_q == idx_q)) ? S_CAPTURE : S_WRITE;
        end

        S_CAPTURE: begin
          respValue_q <= memRData;
          if ((idx_q + C_ONE) == s_q) begin
            respValid_q         <= 1'b1;
            respSize_q          <= s_q - C_ONE;
            size_q[arr_q[SW-1:0]] <= s_q - C_ONE;
            state_q             <= S_RESP;
          end else begin
            i_q     <= idx_q + C_ONE;
            state_q <= S_READ;
          end
        end

        S_WRITE: begin
          if (!op_q) begin
            if (i_q == idx_q) begin
              state_q <= S_INSERT;
            end else begin
              i_q     <= i_q - C_ONE;
              state_q <= S_READ;
            end
          end else begin
            if ((i_q + C_ONE) == s_q) begin
              respValid_q         <= 1'b1;
              respSize_q          <= s_q - C_ONE;
              size_q[arr_q[SW-1:0]] <= s_q - C_ONE;
              state_q             <= S_RESP;
            end else begin
              i_q     <= i_q + C_ONE;
              state_q <= S_READ;
            end
          end
        end

        S_INSERT: begin
          respValid_q         <= 1'b1;
          respSize_q          <= up_size_d;
          size_q[arr_q[SW-1:0]] <= up_size_d;
          state_q             <= S_RESP;
        end

        S_RESP: begin
          if (respReady) begin
            respValid_q <= 1'b0;
            respError_q <= 1'b0;
            respValue_q <= '0;
            respSize_q  <= '0;
            cmdReady_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_heap_shift_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_heap_shift_sequencer                                        |
// | Brief   : Self-checking bench: heap RAM model, queue-based reference     |
// |           model of insert/remove, bus monitor and directed + random ops. |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_heap_shift_sequencer;

  localparam int MEW   = 12;
  localparam int NAREA = 4;
  localparam int NARR  = 2;
  localparam int AW    = 3;
  localparam int DEPTH = NAREA * NARR;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           cmdValid = 1'b0;
  logic           cmdReady;
  logic           cmdOp = 1'b0;
  logic [MEW-1:0] cmdArray = '0;
  logic [MEW-1:0] cmdIndex = '0;
  logic [MEW-1:0] cmdValue = '0;
  logic           sizeWe = 1'b0;
  logic [MEW-1:0] sizeArray = '0;
  logic [MEW-1:0] sizeValue = '0;
  logic           respValid;
  logic           respReady = 1'b0;
  logic           respError;
  logic [MEW-1:0] respValue;
  logic [MEW-1:0] respSize;
  logic [AW-1:0]  memAddr;
  logic           memWe;
  logic [MEW-1:0] memWData;
  logic [MEW-1:0] memRData = '0;

  logic [MEW-1:0] mem [DEPTH] = '{default: '0};
  logic           bd_we = 1'b0;
  logic [AW-1:0]  bd_addr = '0;
  logic [MEW-1:0] bd_data = '0;

  int checks   = 0;
  int failures = 0;
  int ref_heap [DEPTH];
  int ref_size [NARR];
  int mon_en   = 0;
  int mon_err  = 0;
  int mon_base = 0;
  int last_lat, last_err, last_val, last_size;

  heap_shift_sequencer #(
    .MemoryElementWidth(MEW),
    .NArea(NAREA),
    .NArrays(NARR)
  ) dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdArray(cmdArray), .cmdIndex(cmdIndex), .cmdValue(cmdValue),
    .sizeWe(sizeWe), .sizeArray(sizeArray), .sizeValue(sizeValue),
    .respValid(respValid), .respReady(respReady), .respError(respError),
    .respValue(respValue), .respSize(respSize),
    .memAddr(memAddr), .memWe(memWe), .memWData(memWData), .memRData(memRData)
  );

  always #5 clock = ~clock;

  // Single-port heap RAM with one-cycle read latency, plus a preload port.
  always @(posedge clock) begin
    if (bd_we)      mem[bd_addr] <= bd_data;
    else if (memWe) mem[memAddr] <= memWData;
    memRData <= mem[memAddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampa(input int v);
    return (v > NAREA) ? NAREA : v;
  endfunction

  task automatic chk_heap(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(mem[i]) != ref_heap[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic bd_write(input int a, input int d);
    @(negedge clock);
    bd_we = 1'b1; bd_addr = AW'(a); bd_data = MEW'(d);
    @(negedge clock);
    bd_we = 1'b0;
    ref_heap[a] = d;
  endtask

  task automatic set_size(input int a, input int v);
    @(negedge clock);
    sizeWe = 1'b1; sizeArray = MEW'(a); sizeValue = MEW'(v);
    @(negedge clock);
    sizeWe = 1'b0;
    if (a < NARR) ref_size[a] = clampa(v);
  endtask

  // Issue one command, model it with a queue view of the array, check response and heap.
  task automatic do_cmd(input int op, input int arr, input int idx, input int val,
                        input int szwe, input int sza, input int szv,
                        input int hold, input int midsz);
    int s, err, lat, nsz, rval, k, n, base, ma, mv;
    int q[$];
    int nq[$];
    n = 0;
    @(negedge clock);
    while (!cmdReady && n < 20) begin @(negedge clock); n++; end
    chk("cmd_ready_wait", int'(cmdReady), 1);
    if (szwe != 0 && sza < NARR) ref_size[sza] = clampa(szv);
    s    = (arr < NARR) ? ref_size[arr] : 0;
    base = NAREA * arr;
    err  = ((arr >= NARR) || (op == 0 && (idx > s || idx >= NAREA)) ||
            (op == 1 && idx >= s)) ? 1 : 0;
    rval = 0; nsz = s; lat = 1;
    if (err == 0) begin
      for (int j = 0; j < s; j++) q.push_back(ref_heap[base + j]);
      if (op == 0) begin
        for (int j = 0; j < idx; j++) nq.push_back(q[j]);
        nq.push_back(val);
        for (int j = idx; j < s; j++) nq.push_back(q[j]);
        if (nq.size() > NAREA) void'(nq.pop_back());
        lat = 2 * (s - idx) + 2;
      end else begin
        rval = q[idx];
        for (int j = 0; j < s; j++) if (j != idx) nq.push_back(q[j]);
        lat = 2 * (s - idx - 1) + 3;
      end
      nsz = nq.size();
    end
    mon_base = base; mon_err = err;
    cmdValid = 1'b1; cmdOp = (op != 0); cmdArray = MEW'(arr);
    cmdIndex = MEW'(idx); cmdValue = MEW'(val);
    sizeWe = (szwe != 0); sizeArray = MEW'(sza); sizeValue = MEW'(szv);
    @(negedge clock);
    k = 1;
    cmdValid = 1'b0; sizeWe = 1'b0;
    while (!respValid && k < 40) begin
      if (midsz != 0 && $urandom_range(0, 3) == 0) begin
        ma = $urandom_range(0, 2); mv = $urandom_range(0, 6);
        sizeWe = 1'b1; sizeArray = MEW'(ma); sizeValue = MEW'(mv);
        if (ma < NARR && ma != arr) ref_size[ma] = clampa(mv);
      end
      @(negedge clock);
      sizeWe = 1'b0;
      k++;
    end
    chk("resp_latency", k, lat);
    chk("resp_error", int'(respError), err);
    chk("resp_value", int'(respValue), rval);
    chk("resp_size", int'(respSize), nsz);
    last_lat = k; last_err = int'(respError); last_val = int'(respValue); last_size = int'(respSize);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold_valid", int'(respValid), 1);
      chk("hold_value", int'(respValue), rval);
      chk("hold_size", int'(respSize), nsz);
      chk("hold_cmdready", int'(cmdReady), 0);
    end
    respReady = 1'b1;
    @(negedge clock);
    respReady = 1'b0;
    chk("resp_released", int'(respValid), 0);
    if (err == 0) begin
      for (int j = 0; j < nq.size(); j++) ref_heap[base + j] = nq[j];
      ref_size[arr] = nsz;
    end
    chk_heap("heap_after_cmd");
    mon_err = 0;
  endtask

  // Bus monitor: quiet bus in idle, no writes on rejected commands, writes stay in the target area.
  always @(negedge clock) begin
    if (reset && mon_en != 0) begin
      if (cmdReady) begin
        chk("idle_memWe", int'(memWe), 0);
        chk("idle_memAddr", int'(memAddr), 0);
        chk("idle_memWData", int'(memWData), 0);
      end else if (mon_err != 0) begin
        chk("error_no_write", int'(memWe), 0);
      end else if (memWe) begin
        chk("write_in_area",
            (int'(memAddr) >= mon_base && int'(memAddr) < mon_base + NAREA) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) ref_heap[i] = 0;
    for (int a = 0; a < NARR; a++) ref_size[a] = 0;

    repeat (3) @(negedge clock);
    chk("rst_cmdReady", int'(cmdReady), 0);
    chk("rst_respValid", int'(respValid), 0);
    chk("rst_respError", int'(respError), 0);
    chk("rst_respValue", int'(respValue), 0);
    chk("rst_respSize", int'(respSize), 0);
    chk("rst_memWe", int'(memWe), 0);
    chk("rst_memAddr", int'(memAddr), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("ready_after_reset", int'(cmdReady), 1);
    mon_en = 1;

    // array1 = [0,1,2]
    bd_write(4, 0); bd_write(5, 1); bd_write(6, 2);
    set_size(1, 3);

    // Insert 99 at the front.
    do_cmd(0, 1, 0, 99, 0, 0, 0, 0, 0);
    chk("t1_latency", last_lat, 8);
    chk("t1_size", last_size, 4);
    chk("t1_error", last_err, 0);
    chk("t1_h4", int'(mem[4]), 99);
    chk("t1_h5", int'(mem[5]), 0);
    chk("t1_h6", int'(mem[6]), 1);
    chk("t1_h7", int'(mem[7]), 2);

    // Insert into a full area: top element falls off, nothing wraps to address 0.
    do_cmd(0, 1, 0, 7, 0, 0, 0, 0, 0);
    chk("t2_size", last_size, 4);
    chk("t2_h4", int'(mem[4]), 7);
    chk("t2_h5", int'(mem[5]), 99);
    chk("t2_h7", int'(mem[7]), 1);
    chk("t2_no_wrap", int'(mem[0]), 0);

    // Restore the post-insert state, then remove index 1.
    bd_write(4, 99); bd_write(5, 0); bd_write(6, 1); bd_write(7, 2);
    do_cmd(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("t3_value", last_val, 0);
    chk("t3_size", last_size, 3);
    chk("t3_latency", last_lat, 7);
    chk("t3_h5", int'(mem[5]), 1);
    chk("t3_h7_stale", int'(mem[7]), 2);

    // Out-of-range remove.
    do_cmd(1, 1, 5, 0, 0, 0, 0, 0, 0);
    chk("t4_error", last_err, 1);
    chk("t4_latency", last_lat, 1);
    chk("t4_size", last_size, 3);

    // Response held for 10 cycles.
    do_cmd(1, 1, 0, 0, 0, 0, 0, 10, 0);
    chk("t5_value", last_val, 99);

    // Resize landing in the same cycle as the command accept.
    do_cmd(0, 0, 0, 5, 1, 0, 3, 0, 0);
    chk("t7_latency", last_lat, 8);
    chk("t7_size", last_size, 4);
    chk("t7_h0", int'(mem[0]), 5);

    // Random traffic, with resizes before, alongside and during commands.
    repeat (60) begin
      int op, arr, idx, val, szwe, sza, szv, hold;
      op   = $urandom_range(0, 1);
      arr  = ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1);
      idx  = $urandom_range(0, 4);
      val  = $urandom_range(0, 4095);
      szwe = ($urandom_range(0, 5) == 0) ? 1 : 0;
      sza  = $urandom_range(0, 2);
      szv  = $urandom_range(0, 6);
      hold = $urandom_range(0, 3);
      do_cmd(op, arr, idx, val, szwe, sza, szv, hold, 1);
    end

    // Reset while a shiftUp is writing.
    bd_write(4, 0); bd_write(5, 1); bd_write(6, 2);
    set_size(1, 3);
    @(negedge clock);
    chk("t6_ready", int'(cmdReady), 1);
    mon_base = 4; mon_err = 0;
    cmdValid = 1'b1; cmdOp = 1'b0; cmdArray = MEW'(1); cmdIndex = '0; cmdValue = MEW'(99);
    @(negedge clock);
    cmdValid = 1'b0;
    n = 0;
    while (!memWe && n < 20) begin @(negedge clock); n++; end
    chk("t6_reach_write", int'(memWe), 1);
    mon_en = 0;
    #2 reset = 1'b0;
    #1;
    chk("t6_memWe_async", int'(memWe), 0);
    chk("t6_respValid", int'(respValid), 0);
    chk("t6_cmdReady_low", int'(cmdReady), 0);
    @(negedge clock);
    #2 reset = 1'b1;
    for (int a = 0; a < NARR; a++) ref_size[a] = 0;
    chk_heap("t6_heap_untouched");
    repeat (2) @(negedge clock);
    chk("t6_cmdReady_after", int'(cmdReady), 1);
    mon_en = 1;
    do_cmd(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_size_cleared_err", last_err, 1);
    chk("t6_size_cleared", last_size, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
